// File: rtl/alu_input_sequencer_pkg.sv
// Shared definitions for the ALU front end: default widths, the eight ALU opcodes,
// opcode validation and the sequencer FSM state encoding.
package alu_pkg;

  localparam int unsigned NbOperandoDef     = 8;
  localparam int unsigned NbOpcodeDef       = 6;
  localparam int unsigned DebounceCyclesDef = 16;

  // ALU operation codes
  localparam logic [NbOpcodeDef-1:0] OpAdd = 6'b100000;
  localparam logic [NbOpcodeDef-1:0] OpSub = 6'b100010;
  localparam logic [NbOpcodeDef-1:0] OpAnd = 6'b100100;
  localparam logic [NbOpcodeDef-1:0] OpOr  = 6'b100101;
  localparam logic [NbOpcodeDef-1:0] OpXor = 6'b100110;
  localparam logic [NbOpcodeDef-1:0] OpNor = 6'b100111;
  localparam logic [NbOpcodeDef-1:0] OpSra = 6'b000011;
  localparam logic [NbOpcodeDef-1:0] OpSrl = 6'b000010;

  typedef enum logic {
    StLoading,
    StArmed
  } seq_state_e;

  function automatic logic is_valid_opcode(input logic [NbOpcodeDef-1:0] code);
    case (code)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Switch/button/ALU bundle of the input sequencer. The master side drives the raw
// board inputs and the ALU result; the slave side is the sequencer itself.
interface alu_input_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned NB_OPERANDO = NbOperandoDef,
  parameter int unsigned NB_OPCODE   = NbOpcodeDef
);

  logic [NB_OPERANDO-1:0] sw;
  logic                   btn_a;
  logic                   btn_b;
  logic                   btn_op;
  logic                   btn_exec;
  logic [NB_OPERANDO-1:0] alu_out;
  logic [NB_OPERANDO-1:0] dato_a;
  logic [NB_OPERANDO-1:0] dato_b;
  logic [NB_OPCODE-1:0]   opcode;
  logic [NB_OPERANDO-1:0] result;
  logic                   ready;
  logic                   result_valid;
  logic                   op_error;

  modport master (
    output sw, btn_a, btn_b, btn_op, btn_exec, alu_out,
    input  dato_a, dato_b, opcode, result, ready, result_valid, op_error
  );

  modport slave (
    input  sw, btn_a, btn_b, btn_op, btn_exec, alu_out,
    output dato_a, dato_b, opcode, result, ready, result_valid, op_error
  );

endinterface

// File: rtl/alu_input_sequencer_btn_pulse.sv
// Raw button to single-cycle press pulse: 2-FF synchroniser, optional counter
// debounce (ALU_SEQ_DEBOUNCE_EN) and rising-edge detect.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
    $fatal(1, "btn_pulse: DEBOUNCE_CYCLES must be at least 1");
  end

  logic       sync1_q, sync2_q;
  logic       prev_q;
  logic       lvl;
  logic [2:0] warm_q;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // The filter stage adds one register between the synchroniser and the edge detect.
  localparam logic [2:0] WarmCycles = 3'd4;

  logic            filt_q;
  logic [CntW-1:0] cnt_q;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (warm_q != WarmCycles) begin
      // Right after reset the filter tracks the synchroniser so a held button settles
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else if (sync2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  localparam logic [2:0] WarmCycles = 3'd3;

  assign lvl = sync2_q;
`endif

  // Synchroniser and edge-detect history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
    end
  end

  // Post-reset warm-up: pulses stay masked until the pipeline holds the real button
  // level, so a button held through reset release is not seen as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_q <= '0;
    end else if (warm_q != WarmCycles) begin
      warm_q <= warm_q + 1'b1;
    end
  end

  assign pulse = lvl & ~prev_q & (warm_q == WarmCycles);

endmodule

// File: rtl/alu_input_sequencer.sv
// Front end of the 8-op ALU: captures operands and opcode from the switches on
// button presses, presents them as registered ALU inputs and latches the ALU result
// for the LEDs on an execute press once all three have been loaded.
// Optional button debounce: define ALU_SEQ_DEBOUNCE_EN.
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_OPERANDO     = NbOperandoDef,
  parameter int unsigned NB_OPCODE       = NbOpcodeDef,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_input_sequencer_if.slave bus
);

  if (NB_OPCODE > NB_OPERANDO) begin : g_width_check
    $fatal(1, "alu_input_sequencer: NB_OPCODE must not exceed NB_OPERANDO");
  end

  logic pulse_a, pulse_b, pulse_op, pulse_exec;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_a),
    .pulse (pulse_a)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_b),
    .pulse (pulse_b)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_op),
    .pulse (pulse_op)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_exec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_exec),
    .pulse (pulse_exec)
  );

  logic [NB_OPERANDO-1:0] dato_a_q, dato_b_q, result_q;
  logic [NB_OPCODE-1:0]   opcode_q;
  logic                   flag_a_q, flag_b_q, flag_op_q;
  logic                   flag_a_d, flag_b_d, flag_op_d;
  logic                   ready_q, result_valid_q, op_error_q;
  seq_state_e             state_q;
  logic                   op_valid;
  logic                   exec_fire;

  assign op_valid  = is_valid_opcode(bus.sw[NB_OPCODE-1:0]);
  assign exec_fire = pulse_exec && (state_q == StArmed);

  // Load flags: a coincident load wins over the execute clear
  always_comb begin
    flag_a_d  = pulse_a | (flag_a_q & ~exec_fire);
    flag_b_d  = pulse_b | (flag_b_q & ~exec_fire);
    flag_op_d = (pulse_op & op_valid) | (flag_op_q & ~exec_fire);
  end

  // Operand, opcode and load-flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      opcode_q   <= OpAdd;
      op_error_q <= 1'b0;
      flag_a_q   <= 1'b0;
      flag_b_q   <= 1'b0;
      flag_op_q  <= 1'b0;
    end else begin
      if (pulse_a) dato_a_q <= bus.sw;
      if (pulse_b) dato_b_q <= bus.sw;
      if (pulse_op) begin
        if (op_valid) opcode_q <= bus.sw[NB_OPCODE-1:0];
        op_error_q <= ~op_valid;
      end
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      flag_op_q <= flag_op_d;
    end
  end

  // Sequencer FSM with registered ready and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StLoading;
      ready_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      ready_q <= flag_a_d & flag_b_d & flag_op_d & ~exec_fire;
      unique case (state_q)
        StLoading: begin
          if (ready_q) state_q <= StArmed;
        end
        StArmed: begin
          if (pulse_exec) begin
            // alu_out still reflects the pre-update operand registers this cycle
            result_q       <= bus.alu_out;
            result_valid_q <= 1'b1;
            state_q        <= StLoading;
          end
        end
        default: state_q <= StLoading;
      endcase
    end
  end

  assign bus.dato_a       = dato_a_q;
  assign bus.dato_b       = dato_b_q;
  assign bus.opcode       = opcode_q;
  assign bus.result       = result_q;
  assign bus.ready        = ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.op_error     = op_error_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer with a behavioural ALU attached and a result
// scoreboard filled at each execute press.
module tb_alu_input_sequencer;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int Hold = 22;
  localparam int Gap  = 22;
`else
  localparam int Hold = 4;
  localparam int Gap  = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  always #5 clk = ~clk;

  alu_input_sequencer_if #(.NB_OPERANDO(8), .NB_OPCODE(6)) bus ();

  alu_input_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return $signed(a) >>> b;
      6'b000010: return a >> b;
      default:   return 8'h00;
    endcase
  endfunction

  // Attached ALU
  always_comb bus.alu_out = alu_ref(bus.dato_a, bus.dato_b, bus.opcode);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic a, input logic b, input logic op, input logic ex);
    bus.btn_a = a; bus.btn_b = b; bus.btn_op = op; bus.btn_exec = ex;
    tick(Hold);
    bus.btn_a = 1'b0; bus.btn_b = 1'b0; bus.btn_op = 1'b0; bus.btn_exec = 1'b0;
    tick(Gap);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.sw = 8'hAA; bus.btn_a = 1'b1;
    tick(2);
    checks++; if (bus.dato_a !== 8'h00) $display("FAIL rst_dato_a: got %h want 00", bus.dato_a); else passed++;
    checks++; if (bus.dato_b !== 8'h00) $display("FAIL rst_dato_b: got %h want 00", bus.dato_b); else passed++;
    checks++; if (bus.opcode !== 6'b100000) $display("FAIL rst_opcode: got %b want 100000", bus.opcode); else passed++;
    checks++; if (bus.result !== 8'h00) $display("FAIL rst_result: got %h want 00", bus.result); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ready); else passed++;
    checks++; if (bus.result_valid !== 1'b0) $display("FAIL rst_rv: got %b want 0", bus.result_valid); else passed++;
    checks++; if (bus.op_error !== 1'b0) $display("FAIL rst_op_error: got %b want 0", bus.op_error); else passed++;
    rst_n = 1'b1;
    tick(Hold + 4);
    checks++; if (bus.dato_a !== 8'h00) $display("FAIL rst_held_btn: got %h want 00", bus.dato_a); else passed++;
    bus.btn_a = 1'b0;
    tick(Gap);
    checks++; if (bus.dato_a !== 8'h00) $display("FAIL rst_held_release: got %h want 00", bus.dato_a); else passed++;
  endtask

  task automatic test_basic_add;
    bus.sw = 8'h05; press(1, 0, 0, 0);
    checks++; if (bus.dato_a !== 8'h05) $display("FAIL add_dato_a: got %h want 05", bus.dato_a); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL add_ready_early: got %b want 0", bus.ready); else passed++;
    bus.sw = 8'h03; press(0, 1, 0, 0);
    checks++; if (bus.dato_b !== 8'h03) $display("FAIL add_dato_b: got %h want 03", bus.dato_b); else passed++;
    bus.sw = 8'h20; press(0, 0, 1, 0);
    checks++; if (bus.opcode !== 6'b100000) $display("FAIL add_opcode: got %b want 100000", bus.opcode); else passed++;
    checks++; if (bus.ready !== 1'b1) $display("FAIL add_ready: got %b want 1", bus.ready); else passed++;
    exp_q.push_back(8'h08);
    press(0, 0, 0, 1);
    checks++;
    if (exp_q.size() == 0) $display("FAIL add_result: scoreboard empty");
    else begin
      exp = exp_q.pop_front();
      if (bus.result !== exp) $display("FAIL add_result: got %h want %h", bus.result, exp); else passed++;
    end
    checks++; if (bus.result_valid !== 1'b1) $display("FAIL add_rv: got %b want 1", bus.result_valid); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL add_ready_clr: got %b want 0", bus.ready); else passed++;
  endtask

  task automatic test_exec_before_ready;
    bus.sw = 8'h11; press(1, 0, 0, 0);
    bus.sw = 8'h22; press(0, 1, 0, 0);
    checks++; if (bus.ready !== 1'b0) $display("FAIL early_ready: got %b want 0", bus.ready); else passed++;
    press(0, 0, 0, 1);
    checks++; if (bus.result !== 8'h08) $display("FAIL early_result: got %h want 08", bus.result); else passed++;
    checks++; if (bus.result_valid !== 1'b1) $display("FAIL early_rv: got %b want 1", bus.result_valid); else passed++;
    checks++; if (bus.dato_a !== 8'h11) $display("FAIL early_dato_a: got %h want 11", bus.dato_a); else passed++;
  endtask

  task automatic test_invalid_opcode;
    bus.sw = 8'h22; press(0, 0, 1, 0);
    checks++; if (bus.opcode !== 6'b100010) $display("FAIL inv_sub: got %b want 100010", bus.opcode); else passed++;
    checks++; if (bus.ready !== 1'b1) $display("FAIL inv_ready: got %b want 1", bus.ready); else passed++;
    bus.sw = 8'h3F; press(0, 0, 1, 0);
    checks++; if (bus.opcode !== 6'b100010) $display("FAIL inv_hold: got %b want 100010", bus.opcode); else passed++;
    checks++; if (bus.op_error !== 1'b1) $display("FAIL inv_err: got %b want 1", bus.op_error); else passed++;
    bus.sw = 8'h24; press(0, 0, 1, 0);
    checks++; if (bus.opcode !== 6'b100100) $display("FAIL inv_and: got %b want 100100", bus.opcode); else passed++;
    checks++; if (bus.op_error !== 1'b0) $display("FAIL inv_err_clr: got %b want 0", bus.op_error); else passed++;
    exp_q.push_back(8'h00);  // 0x11 & 0x22
    press(0, 0, 0, 1);
    checks++;
    if (exp_q.size() == 0) $display("FAIL and_result: scoreboard empty");
    else begin
      exp = exp_q.pop_front();
      if (bus.result !== exp) $display("FAIL and_result: got %h want %h", bus.result, exp); else passed++;
    end
  endtask

  task automatic test_simultaneous;
    bus.sw = 8'h0F; press(1, 0, 0, 0);
    bus.sw = 8'h01; press(0, 1, 0, 0);
    bus.sw = 8'h02; press(0, 0, 1, 0);
    checks++; if (bus.ready !== 1'b1) $display("FAIL sim_ready: got %b want 1", bus.ready); else passed++;
    bus.sw = 8'hF0;
    exp_q.push_back(8'h07);  // 0x0F >> 1 from pre-update operands
    press(1, 0, 0, 1);
    checks++;
    if (exp_q.size() == 0) $display("FAIL sim_result: scoreboard empty");
    else begin
      exp = exp_q.pop_front();
      if (bus.result !== exp) $display("FAIL sim_result: got %h want %h", bus.result, exp); else passed++;
    end
    checks++; if (bus.dato_a !== 8'hF0) $display("FAIL sim_dato_a: got %h want f0", bus.dato_a); else passed++;
    checks++; if (bus.ready !== 1'b0) $display("FAIL sim_ready_clr: got %b want 0", bus.ready); else passed++;
    bus.sw = 8'h04; press(0, 1, 0, 0);
    checks++; if (bus.ready !== 1'b0) $display("FAIL sim_no_op: got %b want 0", bus.ready); else passed++;
    bus.sw = 8'h03; press(0, 0, 1, 0);
    checks++; if (bus.ready !== 1'b1) $display("FAIL sim_flag_a_kept: got %b want 1", bus.ready); else passed++;
  endtask

  task automatic test_back_to_back;
    // Reload A while armed; SRA 0x81 by 4
    bus.sw = 8'h81; press(1, 0, 0, 0);
    checks++; if (bus.ready !== 1'b1) $display("FAIL b2b_armed: got %b want 1", bus.ready); else passed++;
    exp_q.push_back(8'hF8);
    press(0, 0, 0, 1);
    bus.sw = 8'h10; press(1, 0, 0, 0);
    bus.sw = 8'h20; press(0, 1, 0, 0);
    bus.sw = 8'h22; press(0, 0, 1, 0);
    exp_q.push_back(8'hF0);  // 0x10 - 0x20
    checks++;
    if (exp_q.size() == 0) $display("FAIL b2b_sra: scoreboard empty");
    else begin
      exp = exp_q.pop_front();
      if (bus.result !== exp) $display("FAIL b2b_sra: got %h want %h", bus.result, exp); else passed++;
    end
    press(0, 0, 0, 1);
    checks++;
    if (exp_q.size() == 0) $display("FAIL b2b_sub: scoreboard empty");
    else begin
      exp = exp_q.pop_front();
      if (bus.result !== exp) $display("FAIL b2b_sub: got %h want %h", bus.result, exp); else passed++;
    end
  endtask

  task automatic test_mid_reset;
    bus.sw = 8'h77; press(1, 0, 0, 0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(Gap);
    checks++; if (bus.dato_a !== 8'h00) $display("FAIL mrst_dato_a: got %h want 00", bus.dato_a); else passed++;
    checks++; if (bus.result_valid !== 1'b0) $display("FAIL mrst_rv: got %b want 0", bus.result_valid); else passed++;
    bus.sw = 8'h01; press(0, 1, 0, 0);
    bus.sw = 8'h20; press(0, 0, 1, 0);
    checks++; if (bus.ready !== 1'b0) $display("FAIL mrst_flag_a: got %b want 0", bus.ready); else passed++;
  endtask

`ifdef ALU_SEQ_DEBOUNCE_EN
  task automatic test_debounce;
    bus.sw = 8'h55; bus.btn_a = 1'b1;
    tick(10);
    bus.btn_a = 1'b0;
    tick(25);
    checks++; if (bus.dato_a !== 8'h00) $display("FAIL db_glitch: got %h want 00", bus.dato_a); else passed++;
    bus.sw = 8'h66; bus.btn_a = 1'b1;
    tick(18);
    checks++; if (bus.dato_a !== 8'h00) $display("FAIL db_early: got %h want 00", bus.dato_a); else passed++;
    tick(1);
    checks++; if (bus.dato_a !== 8'h66) $display("FAIL db_load: got %h want 66", bus.dato_a); else passed++;
    bus.sw = 8'h99;
    tick(1);
    bus.btn_a = 1'b0;
    tick(25);
    checks++; if (bus.dato_a !== 8'h66) $display("FAIL db_single: got %h want 66", bus.dato_a); else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.sw = 8'h00;
    bus.btn_a = 1'b0; bus.btn_b = 1'b0; bus.btn_op = 1'b0; bus.btn_exec = 1'b0;
    test_reset();
    test_basic_add();
    test_exec_before_ready();
    test_invalid_opcode();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
`ifdef ALU_SEQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
